// File: rtl/power_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : power_seq_pkg
//  Purpose  : Shared definitions for the power-domain sequencer: FSM state
//             enumeration with fixed 4-bit encodings and the STATE width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package power_seq_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_BOOT    = 4'd0,
        ST_UNRST   = 4'd1,
        ST_CLK_ON  = 4'd2,
        ST_DEISO   = 4'd3,
        ST_RUN     = 4'd4,
        ST_CLK_OFF = 4'd5,
        ST_ISO     = 4'd6,
        ST_SAVE    = 4'd7,
        ST_PWR_DN  = 4'd8,
        ST_OFF     = 4'd9,
        ST_PWR_UP  = 4'd10,
        ST_RESTORE = 4'd11,
        ST_FAULT   = 4'd12
    } state_t;

endpackage : power_seq_pkg
`default_nettype wire

// File: rtl/pseq_ack_sync.sv
`default_nettype none
// ============================================================================
//  Module   : pseq_ack_sync
//  Purpose  : Two-flop synchronizer for the asynchronous power-switch ack.
//             Resets to 1 so that the synchronized ack agrees with the
//             switch being enabled out of reset.
//  Ports    : clk      in  clock, rising edge
//             rst      in  asynchronous active-high reset
//             i_async  in  asynchronous input
//             o_sync   out synchronized output
//  Revision : 1.0  initial release
// ============================================================================
module pseq_ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule : pseq_ack_sync
`default_nettype wire

// File: rtl/power_domain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : power_domain_sequencer
//  Purpose  : Always-on controller sequencing power-down / power-up of one
//             switchable domain (clock enable, isolation, retention
//             save/restore, power switch, domain reset).
//  Ports    : CLK        in  clock, rising edge
//             RST        in  asynchronous active-high reset
//             SLEEP_REQ  in  level request to power down (honoured in RUN)
//             WAKE_REQ   in  level request to power up (honoured in OFF)
//             PSW_ACK    in  async ack from end of switch chain (1=powered)
//             PSW_EN     out power-switch enable
//             ISO_EN     out output isolation enable
//             CLK_EN     out domain clock-gate enable
//             SAVE       out retention save strobe
//             RESTORE    out retention restore strobe
//             DOM_RSTB   out domain reset, active low
//             BUSY       out high in every state except RUN and OFF
//             ERR        out sticky ack-timeout flag
//             STATE      out current FSM state encoding
//  Revision : 1.0  initial release
// ============================================================================
module power_domain_sequencer
    import power_seq_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int RST_DLY  = 4,
    parameter int ISO_DLY  = 2,
    parameter int SAVE_DLY = 2,
    parameter int PWR_TMO  = 200
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               SLEEP_REQ,
    input  logic               WAKE_REQ,
    input  logic               PSW_ACK,
    output logic               PSW_EN,
    output logic               ISO_EN,
    output logic               CLK_EN,
    output logic               SAVE,
    output logic               RESTORE,
    output logic               DOM_RSTB,
    output logic               BUSY,
    output logic               ERR,
    output logic [STATE_W-1:0] STATE
);

    // Counter load values: a state lasting N cycles loads N-1 on entry and
    // advances when the counter reads zero, so a delay of 0 acts as 1.
    localparam logic [CNT_W-1:0] c_boot_ld = CNT_W'(RST_DLY  > 1 ? RST_DLY  - 1 : 0);
    localparam logic [CNT_W-1:0] c_iso_ld  = CNT_W'(ISO_DLY  > 1 ? ISO_DLY  - 1 : 0);
    localparam logic [CNT_W-1:0] c_save_ld = CNT_W'(SAVE_DLY > 1 ? SAVE_DLY - 1 : 0);
    localparam logic [CNT_W-1:0] c_tmo_ld  = CNT_W'(PWR_TMO  > 1 ? PWR_TMO  - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             psw_en_q, psw_en_d;
    logic             iso_en_q, iso_en_d;
    logic             clk_en_q, clk_en_d;
    logic             save_q, save_d;
    logic             restore_q, restore_d;
    logic             dom_rstb_q, dom_rstb_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             ack_s;
    logic             cnt_done;

    pseq_ack_sync u_ack_sync (
        .clk     (CLK),
        .rst     (RST),
        .i_async (PSW_ACK),
        .o_sync  (ack_s)
    );

    // ------------------------------------------------------------------
    // Next-state and shared delay counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cnt_done = (cnt_q == '0);

        case (state_q)
            ST_BOOT:    if (cnt_done) state_d = ST_UNRST;   else cnt_d = cnt_q - CNT_W'(1);
            ST_UNRST:   state_d = ST_CLK_ON;
            ST_CLK_ON:  if (cnt_done) state_d = ST_DEISO;   else cnt_d = cnt_q - CNT_W'(1);
            ST_DEISO:   state_d = ST_RUN;
            ST_RUN:     if (SLEEP_REQ) state_d = ST_CLK_OFF;
            ST_CLK_OFF: state_d = ST_ISO;
            ST_ISO:     if (cnt_done) state_d = ST_SAVE;    else cnt_d = cnt_q - CNT_W'(1);
            ST_SAVE:    if (cnt_done) state_d = ST_PWR_DN;  else cnt_d = cnt_q - CNT_W'(1);
            ST_PWR_DN: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (!ack_s)        state_d = ST_OFF;
                else if (cnt_done) state_d = ST_FAULT;
                else               cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_OFF:     if (WAKE_REQ) state_d = ST_PWR_UP;
            ST_PWR_UP: begin
                if (ack_s)         state_d = ST_RESTORE;
                else if (cnt_done) state_d = ST_FAULT;
                else               cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RESTORE: if (cnt_done) state_d = ST_CLK_ON;  else cnt_d = cnt_q - CNT_W'(1);
            ST_FAULT:   state_d = ST_FAULT;
            default:    state_d = ST_FAULT;
        endcase

        // Load the counter for the state being entered.
        if (state_d != state_q) begin
            case (state_d)
                ST_CLK_ON, ST_ISO:   cnt_d = c_iso_ld;
                ST_SAVE, ST_RESTORE: cnt_d = c_save_ld;
                ST_PWR_DN, ST_PWR_UP: cnt_d = c_tmo_ld;
                ST_BOOT:             cnt_d = c_boot_ld;
                default:             cnt_d = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so registered outputs line up
    // with the state register.
    // ------------------------------------------------------------------
    always_comb begin
        psw_en_d   = 1'b1;
        iso_en_d   = 1'b1;
        clk_en_d   = 1'b0;
        save_d     = 1'b0;
        restore_d  = 1'b0;
        dom_rstb_d = 1'b1;
        busy_d     = 1'b1;
        err_d      = err_q;

        case (state_d)
            ST_BOOT:    dom_rstb_d = 1'b0;
            ST_UNRST:   ;
            ST_CLK_ON:  clk_en_d = 1'b1;
            ST_DEISO: begin
                clk_en_d = 1'b1;
                iso_en_d = 1'b0;
            end
            ST_RUN: begin
                clk_en_d = 1'b1;
                iso_en_d = 1'b0;
                busy_d   = 1'b0;
            end
            ST_CLK_OFF: iso_en_d = 1'b0;
            ST_ISO:     ;
            ST_SAVE:    save_d = 1'b1;
            ST_PWR_DN: begin
                psw_en_d   = 1'b0;
                dom_rstb_d = 1'b0;
            end
            ST_OFF: begin
                psw_en_d   = 1'b0;
                dom_rstb_d = 1'b0;
                busy_d     = 1'b0;
            end
            ST_PWR_UP:  dom_rstb_d = 1'b0;
            ST_RESTORE: restore_d = 1'b1;
            ST_FAULT: begin
                // Leave the switch where it was when the ack went missing.
                psw_en_d   = psw_en_q;
                dom_rstb_d = 1'b0;
                err_d      = 1'b1;
            end
            default:    ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_BOOT;
            cnt_q      <= c_boot_ld;
            psw_en_q   <= 1'b1;
            iso_en_q   <= 1'b1;
            clk_en_q   <= 1'b0;
            save_q     <= 1'b0;
            restore_q  <= 1'b0;
            dom_rstb_q <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            psw_en_q   <= psw_en_d;
            iso_en_q   <= iso_en_d;
            clk_en_q   <= clk_en_d;
            save_q     <= save_d;
            restore_q  <= restore_d;
            dom_rstb_q <= dom_rstb_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign PSW_EN   = psw_en_q;
    assign ISO_EN   = iso_en_q;
    assign CLK_EN   = clk_en_q;
    assign SAVE     = save_q;
    assign RESTORE  = restore_q;
    assign DOM_RSTB = dom_rstb_q;
    assign BUSY     = busy_q;
    assign ERR      = err_q;
    assign STATE    = state_q;

endmodule : power_domain_sequencer
`default_nettype wire
